// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
//
// AXI4 manager that runs one INCR burst at a time for a local command port.
// A write burst streams beats from the local write-data port onto W. A read
// burst streams R beats out to the local read-data port. Every command ends
// with a single completion pulse that carries the final response and an
// error flag. There are no IDs and only one transaction is in flight.
//
// Handshake rule on every channel: a beat transfers on a rising ACLK edge
// where VALID and READY are both high. A VALID source holds its payload
// stable until that edge. READY may be raised before VALID.
//
// Ports
//   ACLK, ARESET          clock; asynchronous active-high reset
//   cmd_*                 command request (valid/ready, write, addr, len)
//   wr_data/valid/ready   local write beats, passed through to W
//   rd_data/last/valid/ready  local read beats, passed through from R
//   rsp_valid/resp/err    one-cycle completion pulse and status
//   AW*, W*, B*, AR*, R*  AXI4 write and read channels
//   dbg_state             current FSM state, for observation
// ---------------------------------------------------------------------------
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY,
  output logic [2:0]            dbg_state
);

  localparam int         BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;

  // Legality of the incoming command. The end of the burst is measured inside
  // its 4KB page, so only the low 12 address bits take part. 17 bits hold the
  // worst case of 4095 + 256 * 128.
  logic [11:0] addr_lo;
  logic [16:0] span_end;
  logic        cmd_bad;

  assign addr_lo  = cmd_addr[11:0];
  assign span_end = 17'(addr_lo) + (17'(cmd_len) + 17'd1) * 17'(BYTES);
  assign cmd_bad  = (span_end > 17'd4096) ||
                    ((addr_lo & 12'(BYTES - 1)) != 12'd0);

  logic w_hs, r_hs;
  assign w_hs = (state_q == WR_DATA) && wr_valid && WREADY;
  assign r_hs = (state_q == RD_DATA) && RVALID && rd_ready;

  // The channel outputs decode directly from the state register. Because of
  // that, an asynchronous reset drops every VALID/READY at once. cmd_ready is
  // also held low while reset is asserted.
  assign cmd_ready = (state_q == IDLE) && !ARESET;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWLEN     = len_q;
  assign ARLEN     = len_q;
  assign AWSIZE    = SIZE;
  assign ARSIZE    = SIZE;
  assign AWVALID   = (state_q == WR_ADDR);
  assign ARVALID   = (state_q == RD_ADDR);
  assign WDATA     = wr_data;
  assign WVALID    = (state_q == WR_DATA) && wr_valid;
  assign WLAST     = WVALID && (cnt_q == len_q);
  assign wr_ready  = (state_q == WR_DATA) && WREADY;
  assign BREADY    = (state_q == WR_RESP);
  assign RREADY    = (state_q == RD_DATA) && rd_ready;
  assign rd_valid  = (state_q == RD_DATA) && RVALID;
  assign rd_data   = RDATA;
  assign rd_last   = (state_q == RD_DATA) && RLAST;
  assign rsp_valid = (state_q == DONE);
  assign rsp_resp  = resp_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = 8'd0;
          resp_d = 2'b00;
          err_d  = 1'b0;
          if (cmd_bad) begin
            // Rejected before any bus activity: report SLVERR-style status.
            resp_d  = 2'b10;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = cmd_write ? WR_ADDR : RD_ADDR;
          end
        end
      end
      WR_ADDR: if (AWREADY) state_d = WR_DATA;
      WR_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = DONE;
        end
      end
      RD_ADDR: if (ARREADY) state_d = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (RRESP > resp_q) resp_d = RRESP;
          // RLAST must appear on the final beat and on no other beat.
          if (RLAST != (cnt_q == len_q)) err_d = 1'b1;
          if (cnt_q == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_master
//
// Directed bench for axi4_burst_master. A behavioural AXI4 slave backs a
// small word memory. The expected queue holds write beats as they are queued
// for driving and read beats as reads are issued. The slave and the read sink
// pop that queue when the DUT produces a beat.
// Inputs change on the falling edge. Outputs are sampled 2 ns later. A
// handshake seen in a sample therefore happens at the next rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4_burst_master;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          rsp_valid, rsp_err;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic          AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic          WVALID, WLAST, WREADY;
  logic [1:0]    BRESP, RRESP;
  logic          BVALID, BREADY;
  logic          RVALID, RLAST, RREADY;
  logic [2:0]    dbg_state;

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int rsp_cnt  = 0;
  int acc_cyc, aw_first_cyc, first_w_cyc, last_w_cyc, last_r_cyc, rsp_cyc;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem  [0:1023];
  logic [DW-1:0] wbuf [0:255];

  always @(negedge ACLK) begin
    #3;
    if (rsp_valid === 1'b1) rsp_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 32'h5A00_0000 | DW'(i);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    int guard = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    #2;
    while (!cmd_ready && guard < 50) begin
      @(negedge ACLK); #2; guard++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_drive(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 400) begin
      @(negedge ACLK);
      wr_valid = 1'b1; wr_data = wbuf[i];
      #2;
      if (wr_ready) i++;
      guard++;
    end
    @(negedge ACLK);
    wr_valid = 1'b0;
  endtask

  task automatic rd_sink(input int n, input bit toggle, input int rlast_at);
    int   i = 0;
    int   guard = 0;
    logic tg = 1'b0;
    while (i < n && guard < 400) begin
      @(negedge ACLK);
      tg = toggle ? ~tg : 1'b1;
      rd_ready = tg;
      #2;
      if (RVALID) chk("rready_mirror", RREADY, rd_ready);
      if (rd_valid && rd_ready) begin
        chk("rd_exp_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q.pop_front());
        chk("rd_last", rd_last, i == rlast_at);
        i++;
      end
      guard++;
    end
    chk("rd_beats", i, n);
    @(negedge ACLK);
    rd_ready = 1'b0;
  endtask

  task automatic wait_rsp(input logic [1:0] er, input logic ee);
    int guard = 0;
    do begin
      @(negedge ACLK); #2; guard++;
    end while (!rsp_valid && guard < 500);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_resp", rsp_resp, er);
    chk("rsp_err", rsp_err, ee);
    chk("cmd_ready_in_done", cmd_ready, 1'b0);
    rsp_cyc = cyc;
    @(negedge ACLK); #2;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("cmd_ready_after", cmd_ready, 1'b1);
  endtask

  task automatic watch_no_bus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK); #2;
      chk("no_awvalid", AWVALID, 1'b0);
      chk("no_arvalid", ARVALID, 1'b0);
    end
  endtask

  // ---------------- slave model ----------------
  task automatic slave_write(input logic [AW-1:0] ea, input logic [7:0] el, input int aw_delay,
                             input int stall_beat, input int stall_cycles, input logic [1:0] bresp);
    int  waited = 0;
    int  b = 0;
    int  stalled = 0;
    int  guard = 0;
    bit  seen = 0;
    int  base = int'(ea) / 4;
    while (guard < 200) begin
      @(negedge ACLK);
      AWREADY = (waited >= aw_delay);
      #2;
      if (AWVALID) begin
        if (!seen) begin aw_first_cyc = cyc; seen = 1; end
        chk("awaddr", AWADDR, ea);
        chk("awlen", AWLEN, el);
        if (AWREADY) break;
        waited++;
      end
      guard++;
    end
    chk("aw_handshake", AWVALID && AWREADY, 1'b1);
    chk("awsize", AWSIZE, 3'd2);
    guard = 0;
    while (b <= int'(el) && guard < 300) begin
      @(negedge ACLK);
      AWREADY = 1'b0;
      WREADY  = !(b == stall_beat && stalled < stall_cycles);
      #2;
      if (WVALID && b == 0 && stalled == 0 && WREADY) first_w_cyc = cyc;
      if (WVALID && WREADY) begin
        chk("w_exp_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("wdata", WDATA, exp_q.pop_front());
        chk("wlast", WLAST, b == int'(el));
        mem[base + b] = WDATA;
        last_w_cyc = cyc;
        b++;
      end else if (WVALID) begin
        stalled++;
        if (exp_q.size() != 0) chk("wdata_hold", WDATA, exp_q[0]);
      end
      guard++;
    end
    chk("w_beats", b, int'(el) + 1);
    @(negedge ACLK);
    WREADY = 1'b0; BVALID = 1'b1; BRESP = bresp;
    #2;
    guard = 0;
    while (!BREADY && guard < 50) begin
      @(negedge ACLK); #2; guard++;
    end
    chk("bready", BREADY, 1'b1);
    @(negedge ACLK);
    BVALID = 1'b0; BRESP = 2'b00;
  endtask

  task automatic slave_read(input logic [AW-1:0] ea, input logic [7:0] el,
                            input int rlast_at, input int rerr_beat);
    int b = 0;
    int guard = 0;
    int base = int'(ea) / 4;
    do begin
      @(negedge ACLK); ARREADY = 1'b1; #2; guard++;
    end while (!ARVALID && guard < 100);
    chk("arvalid", ARVALID, 1'b1);
    chk("araddr", ARADDR, ea);
    chk("arlen", ARLEN, el);
    chk("arsize", ARSIZE, 3'd2);
    guard = 0;
    while (b <= int'(el) && guard < 400) begin
      @(negedge ACLK);
      ARREADY = 1'b0;
      RVALID  = 1'b1;
      RDATA   = mem[base + b];
      RLAST   = (b == rlast_at);
      RRESP   = (b == rerr_beat) ? 2'b10 : 2'b00;
      #2;
      if (RREADY) begin last_r_cyc = cyc; b++; end
      guard++;
    end
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  // ---------------- directed sequence ----------------
  int rsp_before;
  int nb;
  int guard;

  initial begin
    ARESET = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RDATA = '0; RRESP = 0; RVALID = 0; RLAST = 0;
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    #1 ARESET = 1'b1;

    // Reset state
    repeat (2) @(negedge ACLK);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_resp", rsp_resp, 2'b00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_awaddr", AWADDR, 16'h0);
    chk("rst_arlen", ARLEN, 8'h0);
    chk("rst_awsize", AWSIZE, 3'd2);
    chk("rst_arsize", ARSIZE, 3'd2);
    chk("rst_state", dbg_state, 3'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #2;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write burst 0x0100, len 3, data A0..A3
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + 32'(i);
      exp_q.push_back(wbuf[i]);
    end
    fork
      issue_cmd(1'b1, 16'h0100, 8'd3);
      wr_drive(4);
      slave_write(16'h0100, 8'd3, 0, 255, 0, 2'b00);
      wait_rsp(2'b00, 1'b0);
    join
    chk("aw_latency", aw_first_cyc - acc_cyc, 1);
    chk("w_latency", first_w_cyc - acc_cyc, 2);
    chk("b_latency", rsp_cyc - last_w_cyc, 2);

    // Read back with rd_ready toggling
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    fork
      issue_cmd(1'b0, 16'h0100, 8'd3);
      slave_read(16'h0100, 8'd3, 3, 255);
      rd_sink(4, 1'b1, 3);
      wait_rsp(2'b00, 1'b0);
    join
    chk("r_latency", rsp_cyc - last_r_cyc, 1);

    // Write crossing 0x1000: rejected, no bus activity
    fork
      issue_cmd(1'b1, 16'h0FF8, 8'd3);
      wait_rsp(2'b10, 1'b1);
      watch_no_bus(3);
    join
    chk("err_latency", rsp_cyc - acc_cyc, 1);

    // Misaligned write address: rejected
    fork
      issue_cmd(1'b1, 16'h0102, 8'd0);
      wait_rsp(2'b10, 1'b1);
      watch_no_bus(3);
    join

    // Read crossing 0x1000: rejected
    fork
      issue_cmd(1'b0, 16'h0FFC, 8'd1);
      wait_rsp(2'b10, 1'b1);
      watch_no_bus(3);
    join

    // Burst ending exactly on the page boundary is legal; EXOKAY is reported
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom;
      exp_q.push_back(wbuf[i]);
    end
    fork
      issue_cmd(1'b1, 16'h0FF0, 8'd3);
      wr_drive(4);
      slave_write(16'h0FF0, 8'd3, 0, 255, 0, 2'b01);
      wait_rsp(2'b01, 1'b0);
    join

    // Single-beat write: WLAST on the first beat
    wbuf[0] = $urandom;
    exp_q.push_back(wbuf[0]);
    fork
      issue_cmd(1'b1, 16'h0400, 8'd0);
      wr_drive(1);
      slave_write(16'h0400, 8'd0, 0, 255, 0, 2'b00);
      wait_rsp(2'b00, 1'b0);
    join

    // Slave backpressure: AWREADY 5 cycles late, WREADY low 3 cycles on beat 2
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom_range(32'h0000_1000, 32'h7FFF_FFFF);
      exp_q.push_back(wbuf[i]);
    end
    fork
      issue_cmd(1'b1, 16'h0300, 8'd3);
      wr_drive(4);
      slave_write(16'h0300, 8'd3, 5, 2, 3, 2'b00);
      wait_rsp(2'b00, 1'b0);
    join
    for (int i = 0; i < 4; i++) exp_q.push_back(wbuf[i]);
    fork
      issue_cmd(1'b0, 16'h0300, 8'd3);
      slave_read(16'h0300, 8'd3, 3, 255);
      rd_sink(4, 1'b0, 3);
      wait_rsp(2'b00, 1'b0);
    join

    // Read with SLVERR on beat 1 and RLAST early on beat 0
    exp_q.push_back(pat(128));
    exp_q.push_back(pat(129));
    fork
      issue_cmd(1'b0, 16'h0200, 8'd1);
      slave_read(16'h0200, 8'd1, 0, 1);
      rd_sink(2, 1'b0, 0);
      wait_rsp(2'b10, 1'b1);
    join

    // Reset during the second of four write beats
    rsp_before = rsp_cnt;
    AWREADY = 1'b1; WREADY = 1'b1; wr_valid = 1'b1; wr_data = 32'hB0;
    issue_cmd(1'b1, 16'h0500, 8'd3);
    nb = 0;
    guard = 0;
    while (guard < 20) begin
      #2;
      if (WVALID && WREADY) begin
        nb++;
        if (nb == 2) break;
      end
      @(negedge ACLK);
      wr_data = 32'hB0 + 32'(nb);
      guard++;
    end
    chk("mid_burst_reached", nb, 2);
    #2 ARESET = 1'b1;
    #1;
    chk("arst_awvalid", AWVALID, 1'b0);
    chk("arst_wvalid", WVALID, 1'b0);
    chk("arst_wlast", WLAST, 1'b0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_bready", BREADY, 1'b0);
    chk("arst_arvalid", ARVALID, 1'b0);
    chk("arst_rready", RREADY, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_awaddr", AWADDR, 16'h0);
    chk("arst_awlen", AWLEN, 8'h0);
    chk("arst_state", dbg_state, 3'd0);
    wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    #2;
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_state", dbg_state, 3'd0);
    repeat (5) @(negedge ACLK);
    #4;
    chk("no_rsp_after_reset", rsp_cnt - rsp_before, 0);

    chk("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
